fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the IF_ID pipeline register.
- Owns the PC and selects the next PC from sequential (pc+4), branch target (ID-stage Equal/Add_Branch) or jump target.
- Drives a variable-latency instruction-memory req/ack handshake and presents one instruction per cycle to IF_ID.
- Honours hazard-unit stalls and issues the IF_ID flush on a redirect.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_skid_reg.sv | 31 +++
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_reg.sv
// Single-entry buffer holding a word fetched while the pipeline was stalled.
module fetch_skid_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         unload,
    input  logic         clear,
    input  logic [W-1:0] load_word,
    input  logic [W-1:0] load_addr,
    output logic         full,
    output logic [W-1:0] word,
    output logic [W-1:0] addr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            word <= '0;
            addr <= '0;
        end else if (clear || unload) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            word <= load_word;
            addr <= load_addr;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC ownership, next-PC selection, imem handshake and IF_ID feed.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        flush_o,
    output logic [31:0] pc_o
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  drop_addr;
    logic [31:0]  pc_plus4;
    logic [31:0]  target;
    logic         started;
    logic         ack;
    logic         redirect;
    logic         skid_load;
    logic         skid_unload;
    logic         skid_full;
    logic [31:0]  skid_word;
    logic [31:0]  skid_addr;

    // In DROP the pc already holds the redirect target, so the address of the
    // abandoned request is kept separately until its ack arrives.
    assign imem_req_o  = (state == REQ) || (state == DROP);
    assign imem_addr_o = (state == DROP) ? drop_addr : word_align(pc);
    assign ack         = imem_req_o & imem_ack_i;
    assign redirect    = (branch_i | jump_i) & ~stall_i & (state != IDLE);
    assign target      = word_align(branch_i ? branch_addr_i : jump_addr_i);
    assign pc_plus4    = pc + 32'd4;
    assign pc_o        = pc;

    assign skid_load   = (state == REQ) & ack & stall_i;
    assign skid_unload = (state == HOLD) & ~stall_i;

    fetch_skid_reg #(.W(XLEN)) u_skid (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .load      (skid_load),
        .unload    (skid_unload),
        .clear     (redirect),
        .load_word (imem_rdata_i),
        .load_addr (pc_plus4),
        .full      (skid_full),
        .word      (skid_word),
        .addr      (skid_addr)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            drop_addr    <= '0;
            started      <= 1'b0;
            inst_valid_o <= 1'b0;
            inst_o       <= NOP_INST;
            inst_addr_o  <= '0;
            flush_o      <= 1'b0;
        end else begin
            flush_o <= 1'b0;
            if (redirect) begin
                pc           <= target;
                flush_o      <= 1'b1;
                inst_valid_o <= 1'b0;
                inst_o       <= NOP_INST;
                // A request still in flight must be drained before the target is fetched.
                if (imem_req_o && !ack) begin
                    state <= DROP;
                    if (state == REQ) drop_addr <= imem_addr_o;
                end else begin
                    state <= REQ;
                end
            end else begin
                case (state)
                    IDLE: begin
                        inst_valid_o <= 1'b0;
                        if (start_i || started) begin
                            started <= 1'b1;
                            state   <= REQ;
                        end
                    end
                    REQ: begin
                        if (ack) begin
                            pc <= pc_plus4;
                            if (!stall_i) begin
                                inst_o       <= imem_rdata_i;
                                inst_addr_o  <= pc_plus4;
                                inst_valid_o <= 1'b1;
                            end else begin
                                state <= HOLD;
                            end
                        end else begin
                            inst_valid_o <= 1'b0;
                        end
                    end
                    HOLD: begin
                        if (!stall_i) begin
                            inst_valid_o <= skid_full;
                            inst_o       <= skid_word;
                            inst_addr_o  <= skid_addr;
                            state        <= REQ;
                        end
                    end
                    DROP: begin
                        inst_valid_o <= 1'b0;
                        if (ack) state <= REQ;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit against a latency-programmable memory model.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = '0;
    logic        jump_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        flush_o;
    logic [31:0] pc_o;

    fetch_unit dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .stall_i       (stall_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .jump_i        (jump_i),
        .jump_addr_i   (jump_addr_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o),
        .flush_o       (flush_o),
        .pc_o          (pc_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory returns the address as data; ack after lat cycles of a held request.
    logic mem_en = 1'b0;
    int   lat = 1;
    int   cnt;
    assign imem_ack_i   = imem_req_o && mem_en && (cnt >= lat - 1);
    assign imem_rdata_i = imem_addr_o;

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                                 cnt <= 0;
        else if (!imem_req_o || imem_ack_i || !mem_en) cnt <= 0;
        else                                        cnt <= cnt + 1;
    end

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] fetch_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_valid = 0;
    int          n_flush = 0;
    logic        stall_prev = 1'b0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] inst, input logic [31:0] addr);
        exp_t e;
        e.inst = inst;
        e.addr = addr;
        exp_q.push_back(e);
    endtask

    // Outputs are refreshed at an edge only when stall was low there; a held
    // output during a stall is the same instruction, not a new one.
    always @(posedge clk_i) stall_prev <= stall_i;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            prev_pend = 1'b0;
        end else begin
            if (imem_req_o) begin
                if (prev_pend) check32("addr_stable", imem_addr_o, prev_addr);
                if (imem_ack_i) begin
                    if (fetch_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL fetch_addr: unexpected ack at %h", imem_addr_o);
                    end else begin
                        check32("fetch_addr", imem_addr_o, fetch_q.pop_front());
                    end
                end
            end
            prev_pend = imem_req_o && !imem_ack_i;
            prev_addr = imem_addr_o;
            if (flush_o) begin
                n_flush++;
                check32("no_valid_on_flush", {31'd0, inst_valid_o}, 32'd0);
            end
            if (inst_valid_o && !stall_prev) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL inst: unexpected inst %h addr %h", inst_o, inst_addr_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check32("inst", inst_o, e.inst);
                    check32("inst_addr", inst_addr_o, e.addr);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check32({tag, "_req"},       {31'd0, imem_req_o},   32'd0);
        check32({tag, "_valid"},     {31'd0, inst_valid_o}, 32'd0);
        check32({tag, "_inst"},      inst_o,                32'h0000_0000);
        check32({tag, "_inst_addr"}, inst_addr_o,           32'd0);
        check32({tag, "_flush"},     {31'd0, flush_o},      32'd0);
        check32({tag, "_pc"},        pc_o,                  32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout, required finish");
        $fatal(1);
    end

    initial begin
        int v0;
        int f0;
        #2 rst_i = 1'b0;
        next_cycle();
        next_cycle();
        check_reset_vals("reset");
        rst_i = 1'b1;

        // Zero-wait stream from RESET_PC.
        push_exp(32'h0, 32'h4); push_exp(32'h4, 32'h8);
        push_exp(32'h8, 32'hC); push_exp(32'hC, 32'h10);
        fetch_q.push_back(32'h0); fetch_q.push_back(32'h4);
        fetch_q.push_back(32'h8); fetch_q.push_back(32'hC);
        v0 = n_valid;
        lat = 1;
        start_i = 1'b1;
        next_cycle();
        mem_en = 1'b1;
        repeat (4) next_cycle();
        mem_en = 1'b0;
        repeat (3) next_cycle();
        check32("zw_valid_count", n_valid - v0, 32'd4);

        // Three-cycle latency: one instruction every three cycles.
        push_exp(32'h10, 32'h14); push_exp(32'h14, 32'h18);
        fetch_q.push_back(32'h10); fetch_q.push_back(32'h14);
        v0 = n_valid;
        lat = 3;
        mem_en = 1'b1;
        repeat (6) next_cycle();
        mem_en = 1'b0;
        repeat (3) next_cycle();
        check32("lat3_valid_count", n_valid - v0, 32'd2);

        // Four-cycle stall in a zero-wait stream; word 0x1C goes through the skid.
        push_exp(32'h18, 32'h1C); push_exp(32'h1C, 32'h20); push_exp(32'h20, 32'h24);
        fetch_q.push_back(32'h18); fetch_q.push_back(32'h1C); fetch_q.push_back(32'h20);
        v0 = n_valid;
        lat = 1;
        mem_en = 1'b1;
        next_cycle();
        stall_i = 1'b1;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check32("hold_req",       {31'd0, imem_req_o},   32'd0);
            check32("hold_valid",     {31'd0, inst_valid_o}, 32'd1);
            check32("hold_inst",      inst_o,                32'h18);
            check32("hold_inst_addr", inst_addr_o,           32'h1C);
            next_cycle();
        end
        stall_i = 1'b0;
        next_cycle();
        next_cycle();
        mem_en = 1'b0;
        repeat (3) next_cycle();
        check32("stall_valid_count", n_valid - v0, 32'd3);

        // Branch while a request to 0x24 is pending; its data must be dropped.
        push_exp(32'h40, 32'h44);
        fetch_q.push_back(32'h24); fetch_q.push_back(32'h40);
        v0 = n_valid; f0 = n_flush;
        lat = 3;
        mem_en = 1'b1;
        next_cycle();
        branch_i = 1'b1; branch_addr_i = 32'h40;
        next_cycle();
        branch_i = 1'b0;
        @(negedge clk_i);
        check32("drop_flush", {31'd0, flush_o}, 32'd1);
        check32("drop_addr",  imem_addr_o,      32'h24);
        check32("drop_pc",    pc_o,             32'h40);
        next_cycle();
        @(negedge clk_i);
        check32("br_target_addr", imem_addr_o,      32'h40);
        check32("br_flush_off",   {31'd0, flush_o}, 32'd0);
        repeat (3) next_cycle();
        mem_en = 1'b0;
        repeat (3) next_cycle();
        check32("br_valid_count", n_valid - v0, 32'd1);
        check32("br_flush_count", n_flush - f0, 32'd1);

        // Branch+jump together with an ack, then an unaligned jump target.
        push_exp(32'h80, 32'h84); push_exp(32'h40, 32'h44);
        fetch_q.push_back(32'h44); fetch_q.push_back(32'h80);
        fetch_q.push_back(32'h84); fetch_q.push_back(32'h40);
        v0 = n_valid; f0 = n_flush;
        lat = 1;
        mem_en = 1'b1;
        branch_i = 1'b1; branch_addr_i = 32'h80;
        jump_i = 1'b1;   jump_addr_i = 32'h100;
        next_cycle();
        branch_i = 1'b0; jump_i = 1'b0;
        @(negedge clk_i);
        check32("bj_pc",    pc_o,                  32'h80);
        check32("bj_flush", {31'd0, flush_o},      32'd1);
        check32("bj_valid", {31'd0, inst_valid_o}, 32'd0);
        check32("bj_inst",  inst_o,                32'h0000_0000);
        next_cycle();
        mem_en = 1'b0;
        jump_i = 1'b1; jump_addr_i = 32'h43;
        next_cycle();
        jump_i = 1'b0;
        mem_en = 1'b1;
        @(negedge clk_i);
        check32("j43_pc",         pc_o,        32'h40);
        check32("j43_drop_addr",  imem_addr_o, 32'h84);
        next_cycle();
        @(negedge clk_i);
        check32("j43_fetch_addr", imem_addr_o, 32'h40);
        next_cycle();
        mem_en = 1'b0;
        repeat (3) next_cycle();
        check32("bj_valid_count", n_valid - v0, 32'd2);
        check32("bj_flush_count", n_flush - f0, 32'd2);

        // Asynchronous reset in the middle of a pending request.
        lat = 3;
        mem_en = 1'b1;
        next_cycle();
        #2 rst_i = 1'b0;
        #1 check_reset_vals("async_reset");
        mem_en = 1'b0;
        lat = 1;
        next_cycle();
        next_cycle();
        push_exp(32'h0, 32'h4); push_exp(32'h4, 32'h8);
        fetch_q.push_back(32'h0); fetch_q.push_back(32'h4);
        v0 = n_valid;
        rst_i = 1'b1;
        next_cycle();
        mem_en = 1'b1;
        next_cycle();
        next_cycle();
        mem_en = 1'b0;
        repeat (3) next_cycle();
        check32("rst_valid_count", n_valid - v0, 32'd2);

        check32("exp_q_empty",   exp_q.size(),   32'd0);
        check32("fetch_q_empty", fetch_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
